alu_issue_ctrl: RTL

//   Issue stage directly upstream of the 8-op ALU (and/or/xor/nor/lt/add/sub/mod).
//   - Accepts one operation at a time over a valid/ready handshake.
//   - Holds sel/a/b stable for the op's full latency, including the multi-cycle mod.
//   - Captures the ALU result and presents it downstream over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the 8-op ALU (and/or/xor/nor/lt/add/sub/mod).
// Accepts one op over valid/ready, holds sel/a/b for the op's latency,
// captures the ALU result and presents it over a second valid/ready port.
// Optional build macro: ALU_MOD_ZERO_CHECK_EN (mod by zero short-circuits
// to DONE with out_result=0 and out_err=1, never touching the ALU).
module alu_issue_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MOD_LATENCY = 34,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MOD = CNT_W'(MOD_LATENCY);

  state_t           state_q, state_d;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] op_a, op_b;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic [WIDTH-1:0] result_q;
  logic             accept, finish, zero_skip;

`ifdef ALU_MOD_ZERO_CHECK_EN
  assign zero_skip = (in_sel == 3'd7) && (in_b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // The ALU sees the op registers directly, so its inputs only move at acceptance.
  assign alu_sel    = op_sel;
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_start  = start_q;
  assign out_result = result_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = zero_skip ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (cnt == CNT_ONE) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Op registers, wait counter, start pulse and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_sel   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      cnt      <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (accept) begin
        op_sel  <= in_sel;
        op_a    <= in_a;
        op_b    <= in_b;
        cnt     <= (in_sel == 3'd7) ? CNT_MOD : CNT_ONE;
        start_q <= !zero_skip;
        if (zero_skip) result_q <= '0;
      end
      if (state_q == EXEC) cnt <= cnt - CNT_ONE;
      if (finish) result_q <= alu_result;
    end
  end

`ifdef ALU_MOD_ZERO_CHECK_EN
  logic err_q;

  // Error flag: set only by the mod-by-zero short-circuit, cleared by any real capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   err_q <= 1'b0;
    else if (accept && zero_skip) err_q <= 1'b1;
    else if (finish)             err_q <= 1'b0;
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule
